// File: rtl/timer_array_if.sv
// Register bus of the timer array: word-addressed writes, combinational read-back
// and the interrupt outputs.
interface timer_array_if #(
  parameter int N_CH = 2
);
  logic [5:2]      ADD_I;
  logic            WE_I;
  logic [31:0]     DAT_I;
  logic [31:0]     DAT_O;
  logic            IRQ;
  logic [N_CH-1:0] IRQ_VEC;

  modport master (output ADD_I, WE_I, DAT_I, input  DAT_O, IRQ, IRQ_VEC);
  modport slave  (input  ADD_I, WE_I, DAT_I, output DAT_O, IRQ, IRQ_VEC);
endinterface

// File: rtl/timer_array.sv
// Array of independent down-counting timers with per-channel prescaler,
// one-shot/auto-reload modes and sticky, maskable interrupt flags.
module timer_array #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  timer_array_if.slave  bus
);

  typedef enum logic [1:0] {
    SEL_CTRL   = 2'd0,
    SEL_PRESET = 2'd1,
    SEL_COUNT  = 2'd2,
    SEL_STATUS = 2'd3
  } sel_e;

  localparam logic [1:0]       MODE_RELOAD = 2'b01;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef struct packed {
    logic             en;
    logic [1:0]       mode;
    logic             im;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic [PRE_W-1:0] presc;
    logic             pend;
  } chan_t;

  chan_t [N_CH-1:0] ch_q, ch_d;
  logic  [N_CH-1:0] tick;
  logic  [N_CH-1:0] wr_hit;
  logic  [N_CH-1:0] irq_vec;
  logic  [31:0]     rd_data;
  logic  [1:0]      ch_idx;
  sel_e             sel;
  logic             ch_valid;

  assign ch_idx   = bus.ADD_I[5:4];
  assign sel      = sel_e'(bus.ADD_I[3:2]);
  assign ch_valid = ({30'd0, ch_idx} < 32'(N_CH));

  always_comb begin
    tick   = '0;
    wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      tick[i]   = ch_q[i].en && (ch_q[i].presc == ch_q[i].pre);
      wr_hit[i] = bus.WE_I && ch_valid && (ch_idx == 2'(i));
    end
  end

  // NOTE: every output of a combinational block is given a default first, so
  // no path through the ifs below can leave a value held (no latch).
  always_comb begin
    ch_d = ch_q;
    for (int i = 0; i < N_CH; i++) begin
      ch_d[i].presc = (!ch_q[i].en || tick[i]) ? '0 : ch_q[i].presc + PRE_W'(1);

      if (bus.WE_I && ch_valid && (sel == SEL_STATUS) && bus.DAT_I[i])
        ch_d[i].pend = 1'b0;

      // A PRESET write in the same cycle suppresses the tick entirely.
      if (tick[i] && !(wr_hit[i] && (sel == SEL_PRESET))) begin
        if (ch_q[i].count > CNT_ONE) begin
          ch_d[i].count = ch_q[i].count - CNT_ONE;
        end else if (ch_q[i].count == CNT_ONE) begin
          ch_d[i].pend = 1'b1;
          if (ch_q[i].mode == MODE_RELOAD) begin
            ch_d[i].count = ch_q[i].preset;
          end else begin
            ch_d[i].count = '0;
            ch_d[i].en    = 1'b0;
          end
        end
      end

      if (wr_hit[i] && (sel == SEL_CTRL)) begin
        ch_d[i].en   = bus.DAT_I[0];
        ch_d[i].mode = bus.DAT_I[2:1];
        ch_d[i].im   = bus.DAT_I[3];
        ch_d[i].pre  = bus.DAT_I[8 +: PRE_W];
      end

      if (wr_hit[i] && (sel == SEL_PRESET)) begin
        ch_d[i].preset = bus.DAT_I[CNT_W-1:0];
        ch_d[i].count  = bus.DAT_I[CNT_W-1:0];
        ch_d[i].presc  = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  // NOTE: the channel array is a handful of flops rather than a RAM, so it is
  // cleared as a whole by the asynchronous reset.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) ch_q <= '0;
    else       ch_q <= ch_d;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_valid && (ch_idx == 2'(i))) begin
        case (sel)
          SEL_CTRL: begin
            rd_data[0]          = ch_q[i].en;
            rd_data[2:1]        = ch_q[i].mode;
            rd_data[3]          = ch_q[i].im;
            rd_data[8 +: PRE_W] = ch_q[i].pre;
          end
          SEL_PRESET: rd_data[CNT_W-1:0] = ch_q[i].preset;
          SEL_COUNT:  rd_data[CNT_W-1:0] = ch_q[i].count;
          default:    ;
        endcase
      end
    end
    if (ch_valid && (sel == SEL_STATUS)) begin
      for (int j = 0; j < N_CH; j++) rd_data[j] = ch_q[j].pend;
    end
  end

  always_comb begin
    irq_vec = '0;
    for (int i = 0; i < N_CH; i++) irq_vec[i] = ch_q[i].pend & ch_q[i].im;
  end

  assign bus.DAT_O   = rd_data;
  assign bus.IRQ_VEC = irq_vec;
  assign bus.IRQ     = |irq_vec;

endmodule

// File: doc/timer_array.md
TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 Parameter N_CH, default 2, number of independent timer channels (1..4).
REQ-002 Parameter CNT_W, default 32, counter/preset width (8..32).
REQ-003 Parameter PRE_W, default 8, prescaler width (1..8).
REQ-004 CLK_I  input  1  clock; all state updates on rising edge.
REQ-005 RST_I  input  1  reset, asynchronous, active-high.
REQ-006 ADD_I  input  4  word address [5:2]: ADD_I[5:4] = channel index, ADD_I[3:2] = register select.
REQ-007 WE_I  input  1  write enable, one write per cycle.
REQ-008 DAT_I  input  32  write data.
REQ-009 DAT_O  output  32  read data, combinational from ADD_I.
REQ-010 IRQ  output  1  OR of all enabled pending interrupts.
REQ-011 IRQ_VEC  output  N_CH  per-channel masked pending interrupts.

Function
REQ-012 Register map per channel: sel 0 CTRL (R/W), sel 1 PRESET (R/W), sel 2 COUNT (RO), sel 3 STATUS (global, same at every channel index).
REQ-013 CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 treated as one-shot), [3] IM interrupt mask, [8+PRE_W-1:8] PRE; other bits read 0.
REQ-014 STATUS bits [N_CH-1:0] = pending flags; write 1 clears that bit, write 0 no effect; other bits read 0.
REQ-015 Channel index >= N_CH: reads return 0, writes ignored.
REQ-016 PRESET/COUNT reads zero-extended to 32 bits; writes take DAT_I[CNT_W-1:0].
REQ-017 Writes to COUNT ignored.
REQ-018 Write to PRESET loads PRESET and COUNT with the new value and clears that channel's prescaler, effective next cycle.
REQ-019 Per-channel prescaler counts 0..PRE while EN=1; tick asserted in the cycle prescaler == PRE, prescaler then wraps to 0; PRE=0 gives tick every cycle.
REQ-020 Prescaler held at 0 while EN=0.
REQ-021 On tick with EN=1 and COUNT>1: COUNT decrements by 1.
REQ-022 On tick with EN=1 and COUNT==1 (terminal): pending set; one-shot -> COUNT<=0, EN<=0; auto-reload -> COUNT<=PRESET.
REQ-023 COUNT==0 with EN=1: no decrement, no pending, no reload (PRESET=0 halts channel without interrupt).
REQ-024 Period in auto-reload = PRESET*(PRE+1) cycles between consecutive pending sets.
REQ-025 IRQ_VEC[i] = pending[i] & IM[i]; IRQ = |IRQ_VEC; both combinational from registers.
REQ-026 Pending is sticky; cleared only by STATUS W1C or reset; masking does not clear it.
REQ-027 Simultaneous terminal tick and W1C of same channel: set wins, pending stays 1.
REQ-028 Simultaneous terminal tick (one-shot) and CTRL write: CTRL takes written value (EN from DAT_I); pending still set.
REQ-029 Simultaneous tick and PRESET write: PRESET write wins, no decrement, pending not set.
REQ-030 Channels fully independent; write to one channel never alters another's state except STATUS W1C bits.

Reset
REQ-031 RST_I high: all CTRL, PRESET, COUNT, prescalers, pending cleared to 0 immediately, independent of CLK_I.
REQ-032 During and after reset: IRQ=0, IRQ_VEC=0, DAT_O reflects zeroed registers.
REQ-033 Reset mid-count aborts operation; channel idle until reprogrammed.

Verification
REQ-034 Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM, PRE=0) -> COUNT 5,4,3,2,1,0 on successive cycles; IRQ rises with COUNT=0; EN reads 0; COUNT stays 0.
REQ-035 Ch1 PRESET=3, CTRL=0x30B (auto-reload, IM, PRE=3) -> pending sets every 12 cycles; COUNT sequence 3,2,1,3...; W1C STATUS=0x2 drops IRQ, re-asserts 12 cycles after previous set.
REQ-036 Ch0 one-shot with IM=0 reaching terminal -> STATUS=0x1, IRQ=0; then write CTRL IM=1 -> IRQ=1 next cycle.
REQ-037 W1C of ch0 issued in same cycle as ch0 terminal tick -> STATUS bit 0 remains 1, IRQ stays high.
REQ-038 Ch0 counting at COUNT=1000, assert RST_I mid-cycle -> all registers 0 and IRQ=0 before next clock edge; no activity after release.
REQ-039 Read at ADD_I[5:4]=3 with N_CH=2 -> DAT_O=0; write there -> no register changes.
